// File: rtl/noc_pe_bridge.sv
// PE-side NoC bridge: registers inbound switch packets, steers them by mode to the
// scheduler (RX FIFO) or back onto the NoC (TX FIFO), and merges scheduler traffic into TX.
module noc_pe_bridge #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 256,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16,
    localparam int PKT_W     = ADDR_W + DATA_W,
    localparam int OCC_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PKT_W-1:0]  i_data,
    input  logic              i_valid,
    output logic [PKT_W-1:0]  o_data,
    output logic              o_valid,
    input  logic              i_ready,
    input  logic [PKT_W-1:0]  i_host_data,
    input  logic              i_host_valid,
    output logic              o_host_ready,
    output logic [PKT_W-1:0]  o_host_data,
    output logic              o_host_valid,
    input  logic              i_host_ready,
    input  logic [1:0]        i_mode,
    input  logic [ADDR_W-1:0] i_loop_addr,
    output logic [CNT_W-1:0]  o_drop_cnt,
    output logic [OCC_W-1:0]  o_rx_occ,
    output logic [OCC_W-1:0]  o_tx_occ
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);
    localparam logic [1:0] MODE_INV  = 2'b01;
    localparam logic [1:0] MODE_LOOP = 2'b10;

    function automatic logic [PKT_W-1:0] xform(input logic [PKT_W-1:0]  pkt,
                                               input logic [1:0]        mode,
                                               input logic [ADDR_W-1:0] laddr);
        case (mode)
            MODE_INV:  return {pkt[PKT_W-1:DATA_W], ~pkt[DATA_W-1:0]};
            MODE_LOOP: return {laddr, ~pkt[DATA_W-1:0]};
            default:   return pkt;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [OCC_W-1:0] next_occ(input logic [OCC_W-1:0] occ,
                                                  input logic push, input logic pop);
        case ({push, pop})
            2'b10:   return occ + OCC_W'(1);
            2'b01:   return occ - OCC_W'(1);
            default: return occ;
        endcase
    endfunction

    // Input stage: packet, mode and loop address captured together
    logic              stage_v_q;
    logic [PKT_W-1:0]  stage_pkt_q;
    logic [1:0]        stage_mode_q;
    logic [ADDR_W-1:0] stage_addr_q;

    always_ff @(posedge clk) begin
        if (rst) stage_v_q <= 1'b0;
        else     stage_v_q <= i_valid;
    end

    always_ff @(posedge clk) begin
        if (i_valid) begin
            stage_pkt_q  <= i_data;
            stage_mode_q <= i_mode;
            stage_addr_q <= i_loop_addr;
        end
    end

    logic [PKT_W-1:0] stage_xf;
    logic             stage_loop, stage_rx;
    assign stage_xf   = xform(stage_pkt_q, stage_mode_q, stage_addr_q);
    assign stage_loop = stage_v_q && (stage_mode_q == MODE_LOOP);
    assign stage_rx   = stage_v_q && (stage_mode_q != MODE_LOOP);

    // FIFO state
    logic [PKT_W-1:0] rx_mem [FIFO_DEPTH];
    logic [PKT_W-1:0] tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [PTR_W-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [OCC_W-1:0] rx_occ_q, rx_occ_d, tx_occ_q, tx_occ_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic rx_full, tx_full, rx_push, rx_pop, tx_push, tx_pop;
    logic loop_push, host_push, drop;
    logic [PKT_W-1:0] tx_wdata;

    // Full is judged on the registered occupancy, so a same-cycle pop never frees a slot
    assign rx_full = (rx_occ_q == DEPTH_C);
    assign tx_full = (tx_occ_q == DEPTH_C);

    assign rx_push   = stage_rx && !rx_full;
    assign loop_push = stage_loop && !tx_full;
    assign drop      = (stage_rx && rx_full) || (stage_loop && tx_full);

    // A pending loopback packet owns the TX write port this cycle
    assign o_host_ready = !rst && !tx_full && !stage_loop;
    assign host_push    = i_host_valid && o_host_ready;
    assign tx_push      = loop_push || host_push;
    assign tx_wdata     = loop_push ? stage_xf : i_host_data;

    assign o_host_valid = (rx_occ_q != '0);
    assign o_valid      = (tx_occ_q != '0);
    assign rx_pop       = o_host_valid && i_host_ready;
    assign tx_pop       = o_valid && i_ready;

    always_comb begin
        rx_wr_d  = rx_push ? rx_wr_q + PTR_W'(1) : rx_wr_q;
        rx_rd_d  = rx_pop  ? rx_rd_q + PTR_W'(1) : rx_rd_q;
        tx_wr_d  = tx_push ? tx_wr_q + PTR_W'(1) : tx_wr_q;
        tx_rd_d  = tx_pop  ? tx_rd_q + PTR_W'(1) : tx_rd_q;
        rx_occ_d = next_occ(rx_occ_q, rx_push, rx_pop);
        tx_occ_d = next_occ(tx_occ_q, tx_push, tx_pop);
        drop_d   = drop ? sat_inc(drop_q) : drop_q;
    end

    // FIFO / counter state update
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            rx_occ_q <= '0;
            tx_occ_q <= '0;
            drop_q   <= '0;
        end else begin
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            rx_occ_q <= rx_occ_d;
            tx_occ_q <= tx_occ_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_q] <= stage_xf;
        if (tx_push) tx_mem[tx_wr_q] <= tx_wdata;
    end

    assign o_host_data = rx_mem[rx_rd_q];
    assign o_data      = tx_mem[tx_rd_q];
    assign o_rx_occ    = rx_occ_q;
    assign o_tx_occ    = tx_occ_q;
    assign o_drop_cnt  = drop_q;

endmodule

// File: tb/tb_noc_pe_bridge.sv
// Bench for noc_pe_bridge: vector table for the mode transforms plus directed
// sequences for full/drop, TX arbitration, full-with-pop and mid-traffic reset.
module tb_noc_pe_bridge;

    localparam int PKT_W = 264;

    logic              clk;
    logic              rst;
    logic [PKT_W-1:0]  i_data;
    logic              i_valid;
    logic [PKT_W-1:0]  o_data;
    logic              o_valid;
    logic              i_ready;
    logic [PKT_W-1:0]  i_host_data;
    logic              i_host_valid;
    logic              o_host_ready;
    logic [PKT_W-1:0]  o_host_data;
    logic              o_host_valid;
    logic              i_host_ready;
    logic [1:0]        i_mode;
    logic [7:0]        i_loop_addr;
    logic [15:0]       o_drop_cnt;
    logic [4:0]        o_rx_occ;
    logic [4:0]        o_tx_occ;

    noc_pe_bridge dut (
        .clk(clk), .rst(rst),
        .i_data(i_data), .i_valid(i_valid),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .i_host_data(i_host_data), .i_host_valid(i_host_valid), .o_host_ready(o_host_ready),
        .o_host_data(o_host_data), .o_host_valid(o_host_valid), .i_host_ready(i_host_ready),
        .i_mode(i_mode), .i_loop_addr(i_loop_addr),
        .o_drop_cnt(o_drop_cnt), .o_rx_occ(o_rx_occ), .o_tx_occ(o_tx_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [PKT_W-1:0] rx_exp[$];
    logic [PKT_W-1:0] tx_exp[$];

    typedef struct packed {
        logic [1:0]       mode;
        logic [7:0]       laddr;
        logic [7:0]       addr;
        logic [255:0]     pay;
        logic             to_host;
        logic [PKT_W-1:0] exp;
    } vec_t;
    vec_t vt[5];

    task automatic chk(input string name, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every transfer on either output is compared in order
    always @(negedge clk) begin
        if (o_host_valid === 1'b1 && i_host_ready === 1'b1) begin
            if (rx_exp.size() == 0) chk("rx_unexpected", o_host_data, 'x);
            else chk("rx_order", o_host_data, rx_exp.pop_front());
        end
        if (o_valid === 1'b1 && i_ready === 1'b1) begin
            if (tx_exp.size() == 0) chk("tx_unexpected", o_data, 'x);
            else chk("tx_order", o_data, tx_exp.pop_front());
        end
    end

    function automatic logic [PKT_W-1:0] mkpkt(input int i);
        logic [31:0] w;
        w = 32'(i) * 32'h0101_0101 ^ 32'hA5C3_0000;
        return {8'(i + 8'h40), {8{w}}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_send(input logic [PKT_W-1:0] p);
        int  n;
        logic rdy;
        n = 0;
        rdy = 1'b0;
        i_host_data  = p;
        i_host_valid = 1'b1;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = o_host_ready;
            @(posedge clk);
            n++;
        end
        #1;
        i_host_valid = 1'b0;
        if (rdy) tx_exp.push_back(p);
        else chk("host_send_timeout", 0, 1);
    endtask

    task automatic drain_rx();
        int n;
        n = 0;
        i_host_ready = 1'b1;
        while (o_host_valid && n < 100) begin tick(); n++; end
        chk("rx_drain_empty", o_host_valid, 0);
        chk("rx_drain_queue", rx_exp.size(), 0);
    endtask

    task automatic drain_tx();
        int n;
        n = 0;
        i_ready = 1'b1;
        while (o_valid && n < 100) begin tick(); n++; end
        i_ready = 1'b0;
        chk("tx_drain_empty", o_valid, 0);
        chk("tx_drain_queue", tx_exp.size(), 0);
    endtask

    initial begin
        vt[0] = '{mode:2'b00, laddr:8'h00, addr:8'h12, pay:{32{8'hA5}}, to_host:1'b1,
                  exp:{8'h12, {32{8'hA5}}}};
        vt[1] = '{mode:2'b01, laddr:8'h00, addr:8'h56, pay:{32{8'h0F}}, to_host:1'b1,
                  exp:{8'h56, {32{8'hF0}}}};
        vt[2] = '{mode:2'b10, laddr:8'h34, addr:8'h77, pay:{32{8'h0F}}, to_host:1'b0,
                  exp:{8'h34, {32{8'hF0}}}};
        vt[3] = '{mode:2'b11, laddr:8'h99, addr:8'h9A, pay:{16{16'h1234}}, to_host:1'b1,
                  exp:{8'h9A, {16{16'h1234}}}};
        vt[4] = '{mode:2'b01, laddr:8'hEE, addr:8'hC3, pay:{8{32'hDEADBEEF}}, to_host:1'b1,
                  exp:{8'hC3, {8{32'h21524110}}}};

        rst = 1'b1; i_valid = 0; i_data = '0; i_ready = 0; i_host_data = '0;
        i_host_valid = 0; i_host_ready = 0; i_mode = 0; i_loop_addr = 0;
        tick();
        i_host_valid = 1'b1;
        @(negedge clk);
        chk("reset_host_ready", o_host_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        i_host_valid = 1'b0;
        chk("reset_o_valid", o_valid, 0);
        chk("reset_o_host_valid", o_host_valid, 0);
        chk("reset_rx_occ", o_rx_occ, 0);
        chk("reset_tx_occ", o_tx_occ, 0);
        chk("reset_drop", o_drop_cnt, 0);

        // Mode transform table, latency and single-cycle delivery
        i_host_ready = 1'b1;
        i_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            i_valid = 1'b1;
            i_data = {vt[v].addr, vt[v].pay};
            i_mode = vt[v].mode;
            i_loop_addr = vt[v].laddr;
            if (vt[v].to_host) rx_exp.push_back(vt[v].exp);
            else tx_exp.push_back(vt[v].exp);
            tick();
            i_valid = 1'b0;
            i_mode = ~vt[v].mode;
            i_loop_addr = 8'hFF;
            chk("vec_early", {o_host_valid, o_valid}, 2'b00);
            tick();
            if (vt[v].to_host) begin
                chk("vec_host_valid", {o_host_valid, o_valid}, 2'b10);
                chk("vec_host_data", o_host_data, vt[v].exp);
            end else begin
                chk("vec_loop_valid", {o_host_valid, o_valid}, 2'b01);
                chk("vec_loop_data", o_data, vt[v].exp);
            end
            tick();
            chk("vec_one_cycle", {o_host_valid, o_valid}, 2'b00);
        end
        i_ready = 1'b0;
        i_mode = 2'b00;

        // Full RX: 19 packets, first 16 kept, 3 dropped
        i_host_ready = 1'b0;
        for (int i = 0; i < 19; i++) begin
            i_valid = 1'b1;
            i_data = mkpkt(i);
            if (i < 16) rx_exp.push_back(mkpkt(i));
            tick();
        end
        i_valid = 1'b0;
        tick();
        chk("full_rx_occ", o_rx_occ, 16);
        chk("full_drop_cnt", o_drop_cnt, 3);
        drain_rx();
        chk("drop_hold", o_drop_cnt, 3);
        i_host_ready = 1'b0;

        // TX arbitration: loopback beats host at depth 15
        for (int i = 0; i < 15; i++) host_send(mkpkt(100 + i));
        chk("arb_tx15", o_tx_occ, 15);
        i_valid = 1'b1;
        i_mode = 2'b10;
        i_loop_addr = 8'h5A;
        i_data = {8'h01, {8{32'h0000FFFF}}};
        tx_exp.push_back({8'h5A, {8{32'hFFFF0000}}});
        tick();
        i_valid = 1'b0;
        i_mode = 2'b00;
        i_host_data = mkpkt(200);
        i_host_valid = 1'b1;
        chk("arb_host_blocked", o_host_ready, 0);
        tick();
        chk("arb_tx16", o_tx_occ, 16);
        chk("arb_full_ready", o_host_ready, 0);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("arb_after_pop_occ", o_tx_occ, 15);
        chk("arb_after_pop_ready", o_host_ready, 1);
        tick();
        i_host_valid = 1'b0;
        tx_exp.push_back(mkpkt(200));
        chk("arb_host_taken", o_tx_occ, 16);
        drain_tx();

        // Full TX with simultaneous pop rejects the push
        for (int i = 0; i < 16; i++) host_send(mkpkt(300 + i));
        chk("fwp_tx16", o_tx_occ, 16);
        i_host_data = mkpkt(400);
        i_host_valid = 1'b1;
        i_ready = 1'b1;
        chk("fwp_ready", o_host_ready, 0);
        tick();
        i_ready = 1'b0;
        chk("fwp_occ15", o_tx_occ, 15);
        chk("fwp_ready_next", o_host_ready, 1);
        tick();
        i_host_valid = 1'b0;
        tx_exp.push_back(mkpkt(400));
        chk("fwp_occ16", o_tx_occ, 16);
        drain_tx();

        // Reset with both FIFOs half full and drop count at 5
        i_host_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            i_valid = 1'b1;
            i_data = mkpkt(500 + i);
            if (i < 16) rx_exp.push_back(mkpkt(500 + i));
            tick();
        end
        i_valid = 1'b0;
        tick();
        chk("pre_rst_drop", o_drop_cnt, 5);
        i_host_ready = 1'b1;
        repeat (8) tick();
        i_host_ready = 1'b0;
        chk("pre_rst_rx8", o_rx_occ, 8);
        for (int i = 0; i < 8; i++) host_send(mkpkt(600 + i));
        chk("pre_rst_tx8", o_tx_occ, 8);
        i_valid = 1'b1;
        i_data = mkpkt(700);
        tick();
        rst = 1'b1;
        i_data = mkpkt(701);
        @(negedge clk);
        chk("mid_rst_host_ready", o_host_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        i_valid = 1'b0;
        rx_exp.delete();
        tx_exp.delete();
        chk("post_rst_rx_occ", o_rx_occ, 0);
        chk("post_rst_tx_occ", o_tx_occ, 0);
        chk("post_rst_valids", {o_host_valid, o_valid}, 2'b00);
        chk("post_rst_drop", o_drop_cnt, 0);
        tick();
        chk("post_rst_stage_discard", o_rx_occ, 0);
        i_host_ready = 1'b1;
        i_valid = 1'b1;
        i_mode = 2'b01;
        i_data = {8'h3C, {32{8'h0F}}};
        rx_exp.push_back({8'h3C, {32{8'hF0}}});
        tick();
        i_valid = 1'b0;
        i_mode = 2'b00;
        tick();
        chk("post_rst_deliver_valid", o_host_valid, 1);
        chk("post_rst_deliver_data", o_host_data, {8'h3C, {32{8'hF0}}});
        tick();
        chk("post_rst_rx_queue", rx_exp.size(), 0);
        chk("post_rst_tx_queue", tx_exp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_pe_bridge.md
Name: noc_pe_bridge

Overview:
Parametrised PE-side network interface between a NoC switch port and the PCI scheduler. It registers inbound NoC packets and steers them by mode into an internal RX FIFO toward the scheduler, or applies a loopback transform back onto the NoC. Scheduler traffic and loopback traffic are buffered in an internal TX FIFO toward the switch. No vendor FIFO IP is used; depth, widths and mode handling are configurable.

Parameters:
ADDR_W, 8, destination-address field width (packet bits [PKT_W-1:DATA_W])
DATA_W, 256, payload field width (packet bits [DATA_W-1:0])
FIFO_DEPTH, 16, entries per FIFO; power of 2, >=2
CNT_W, 16, drop-counter width
(derived) PKT_W = ADDR_W+DATA_W; OCC_W = log2(FIFO_DEPTH)+1

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
i_data  in  PKT_W  packet from switch
i_valid  in  1  packet valid from switch; no backpressure to switch
o_data  out  PKT_W  packet to switch (TX FIFO head)
o_valid  out  1  TX FIFO non-empty
i_ready  in  1  switch accepts o_data
i_host_data  in  PKT_W  scheduler packet toward NoC
i_host_valid  in  1  scheduler packet valid
o_host_ready  out  1  bridge accepts scheduler packet
o_host_data  out  PKT_W  packet to scheduler (RX FIFO head)
o_host_valid  out  1  RX FIFO non-empty
i_host_ready  in  1  scheduler accepts o_host_data
i_mode  in  2  00 pass, 01 invert-to-host, 10 loopback, 11 reserved (= 00)
i_loop_addr  in  ADDR_W  destination used in loopback mode
o_drop_cnt  out  CNT_W  inbound packets dropped, saturating
o_rx_occ  out  OCC_W  RX FIFO occupancy
o_tx_occ  out  OCC_W  TX FIFO occupancy

Behaviour:
- Reset: FIFOs emptied (pointers, occupancy = 0), stage valid = 0, o_valid = o_host_valid = 0, o_host_ready = 0 during the reset cycle, o_drop_cnt = 0. Data outputs are don't-care while their valid is 0.
- Input stage: i_valid captures i_data into a stage register at the next edge (stage_v = 1). i_mode and i_loop_addr are sampled at that capture edge, together with the data.
- Transform applied to the stage output:
  - 00/11: packet unchanged.
  - 01: payload bitwise-inverted, address unchanged.
  - 10: payload inverted, address replaced by the sampled i_loop_addr.
- Steering: modes 00/01/11 push to the RX FIFO; mode 10 pushes to the TX FIFO.
- Drop rule: if the target FIFO is full when stage_v = 1, the packet is discarded and o_drop_cnt increments, holding at all-ones. The stage never stalls, because the switch side has no ready.
- FIFO rules, identical for RX and TX:
  - Push is allowed only if occupancy < FIFO_DEPTH, evaluated before the same-cycle pop. A full FIFO with a simultaneous pop still rejects the push.
  - Pop occurs on valid && ready.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - First-word fall-through: the head is visible whenever occupancy > 0.
- TX arbitration:
  - A loopback push has priority over a host push.
  - o_host_ready = !rst && tx_occ < FIFO_DEPTH && !(stage_v && mode==10).
  - Host handshake = i_host_valid && o_host_ready; the packet is written unchanged.
- Latency:
  - Inbound i_valid at edge N gives o_host_valid at N+2 (empty RX, no backpressure). Loopback o_valid is likewise at N+2.
  - A host handshake at edge N gives o_valid at N+1 (empty TX).
- Ordering: each FIFO is strictly in order. A dropped packet does not disturb later packets.
- Reset mid-operation: all buffered packets are lost, the counter is cleared, and the inbound stage packet is discarded without counting.

Test Plan:
- Pass: mode 00; send addr 0x12 / payload 0xA5…A5 at edge 0, i_host_ready = 1. Required: o_host_valid at edge 2 with the identical packet, for exactly 1 cycle.
- Invert/loopback:
  - Mode 01, payload 0x0F…0F: host receives 0xF0…F0, address unchanged.
  - Mode 10, i_loop_addr = 0x34: o_data = {0x34, inverted payload}, o_valid at edge 2, RX untouched.
- Full/drop: i_host_ready = 0; send FIFO_DEPTH+3 packets (mode 00). Required: o_rx_occ = 16, o_drop_cnt = 3. Draining then returns packets 0..15 in order.
- Arbitration: TX at depth 15; a host packet and a loopback packet arrive in the same cycle. Required: the loopback packet is written, o_host_ready = 0 that cycle, and the host packet is accepted after one switch pop.
- Full with pop: TX full, i_ready = 1 and a host push in the same cycle. Required: push rejected (o_host_ready = 0), o_tx_occ = 15; the push is accepted the next cycle.
- Reset mid-traffic: rst high for 1 cycle with both FIFOs half full and the drop count at 5. Required: next cycle all occupancies = 0, o_valid = o_host_valid = 0, o_drop_cnt = 0, and the first post-reset packet is delivered correctly.
